// File: rtl/vga_pkg.sv
// vga_pkg: types and defaults shared by the VGA ROM-side blocks.
//   ROM_AW_DEF / ROM_DW_DEF : default ROM address / data widths
//   owner_t                 : which requester owns a ROM read in flight
//   state_t                 : aux starvation watchdog states
package vga_pkg;

  localparam int ROM_AW_DEF = 11;
  localparam int ROM_DW_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_STARVED = 2'd2
  } state_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: requester-side bus of the ROM port arbiter.
//   vid_req/vid_addr -> vid_valid/vid_data : video read, always accepted
//   aux_req/aux_addr <-> aux_gnt           : aux valid/ready request
//   aux_valid/aux_data                     : aux read return
//   master: requester view, slave: arbiter view
interface rom_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_gnt;
  logic          aux_valid;
  logic [DW-1:0] aux_data;

  modport master (
    output vid_req, vid_addr, aux_req, aux_addr,
    input  vid_valid, vid_data, aux_gnt, aux_valid, aux_data
  );

  modport slave (
    input  vid_req, vid_addr, aux_req, aux_addr,
    output vid_valid, vid_data, aux_gnt, aux_valid, aux_data
  );
endinterface

// File: rtl/rom_tag_pipe.sv
// rom_tag_pipe: DEPTH-stage shift register of owner tags, aligning each
// issued read's owner with the ROM data that comes back DEPTH cycles later.
//   clk, rst_n : clock, async active-low reset (stages clear to OWN_NONE)
//   tag_i      : owner of the read issued this cycle
//   tag_o      : owner of the read whose data is on rom_data now
module rom_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= OWN_NONE;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one synchronous ROM port between the VGA video
// fetch path (strict priority, fixed ROM_LAT+2 latency) and an aux
// valid/ready requester served only in cycles video leaves idle.
//   clk, rst_n        : pixel clock, async active-low reset
//   bus (slave)       : video and aux request/return signals
//   rom_addr/rom_data : registered ROM address, ROM read data
//   starve/starve_clr : sticky aux starvation flag and its clear
// Optional: ROM_ARB_STATS_EN adds stats_clr, vid_rd_cnt, aux_rd_cnt.
//
// Starvation watchdog:
//   state      | meaning
//   ST_IDLE    | aux not blocked by video
//   ST_WAITING | aux held off, wcnt_q counts blocked cycles
//   ST_STARVED | aux blocked STARVE_MAX cycles; starve held until starve_clr
module rom_port_arbiter
  import vga_pkg::*;
#(
  parameter int ROM_AW     = ROM_AW_DEF,
  parameter int ROM_DW     = ROM_DW_DEF,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4096,
  parameter int WCNT_W     = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_port_arbiter_if.slave bus,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  output logic              starve,
  input  logic              starve_clr
`ifdef ROM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       vid_rd_cnt,
  output logic [15:0]       aux_rd_cnt
`endif
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(STARVE_MAX - 1);

  logic vid_acc, aux_acc, aux_wait;

  // Grant is gated by reset so every output reads 0 while in reset.
  assign bus.aux_gnt = rst_n & bus.aux_req & ~bus.vid_req;
  assign vid_acc     = bus.vid_req;
  assign aux_acc     = bus.aux_gnt;
  assign aux_wait    = bus.aux_req & bus.vid_req;

  // Issue stage
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  owner_t            issue_tag_q, issue_tag_d;

  always_comb begin
    rom_addr_d  = rom_addr_q;
    issue_tag_d = OWN_NONE;
    if (vid_acc) begin
      rom_addr_d  = bus.vid_addr;
      issue_tag_d = OWN_VID;
    end else if (aux_acc) begin
      rom_addr_d  = bus.aux_addr;
      issue_tag_d = OWN_AUX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      issue_tag_q <= OWN_NONE;
    end else begin
      rom_addr_q  <= rom_addr_d;
      issue_tag_q <= issue_tag_d;
    end
  end

  assign rom_addr = rom_addr_q;

  // Tag delayed to line up with rom_data
  owner_t ret_tag;

  rom_tag_pipe #(.DEPTH(ROM_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (issue_tag_q),
    .tag_o (ret_tag)
  );

  // Return stage
  logic              vid_valid_q, aux_valid_q;
  logic [ROM_DW-1:0] vid_data_q, aux_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_valid_q <= 1'b0;
      aux_valid_q <= 1'b0;
      vid_data_q  <= '0;
      aux_data_q  <= '0;
    end else begin
      vid_valid_q <= (ret_tag == OWN_VID);
      aux_valid_q <= (ret_tag == OWN_AUX);
      if (ret_tag == OWN_VID) vid_data_q <= rom_data;
      if (ret_tag == OWN_AUX) aux_data_q <= rom_data;
    end
  end

  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.aux_valid = aux_valid_q;
  assign bus.aux_data  = aux_data_q;

  // Starvation watchdog. The entry cycle counts as the first blocked
  // cycle, so the flag sets after exactly STARVE_MAX blocked cycles.
  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (starve_clr) begin
      wcnt_d = '0;
      if (state_q == ST_STARVED) state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aux_wait) begin
            if (STARVE_MAX <= 1) begin
              state_d = ST_STARVED;
            end else begin
              state_d = ST_WAITING;
              wcnt_d  = WCNT_W'(1);
            end
          end
        end
        ST_WAITING: begin
          if (!aux_wait) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
          end else if (wcnt_q == WCNT_LAST) begin
            state_d = ST_STARVED;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        ST_STARVED: ;
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign starve = (state_q == ST_STARVED);

`ifdef ROM_ARB_STATS_EN
  logic [15:0] vid_cnt_q, aux_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_cnt_q <= '0;
      aux_cnt_q <= '0;
    end else if (stats_clr) begin
      vid_cnt_q <= '0;
      aux_cnt_q <= '0;
    end else begin
      if (vid_acc) vid_cnt_q <= vid_cnt_q + 16'd1;
      if (aux_acc) aux_cnt_q <= aux_cnt_q + 16'd1;
    end
  end

  assign vid_rd_cnt = vid_cnt_q;
  assign aux_rd_cnt = aux_cnt_q;
`endif

endmodule
